// File: rtl/gate_trainer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_trainer_pkg
// Brief    : Shared gate encodings, vector-space sizes and self-test FSM states
// Revision : 1.0
// ============================================================================
package gate_trainer_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;
    localparam logic [2:0] GATE_NOTA = 3'd6;

    localparam int         NUM_GATES   = 7;
    localparam int         NUM_VECTORS = 28;
    localparam logic [4:0] NO_FAIL     = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : gate_trainer_pkg
`default_nettype wire

// File: rtl/gate_trainer_golden.sv
`default_nettype none
// ============================================================================
// Module   : gate_trainer_golden
// Brief    : Combinational reference model of the trainer gate unit
// Revision : 1.0
// ============================================================================
module gate_trainer_golden
    import gate_trainer_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] sel,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            GATE_AND:  y = a & b;
            GATE_OR:   y = a | b;
            GATE_NAND: y = ~(a & b);
            GATE_NOR:  y = ~(a | b);
            GATE_XOR:  y = a ^ b;
            GATE_XNOR: y = ~(a ^ b);
            GATE_NOTA: y = ~a;
            default:   y = 1'b0;
        endcase
    end

endmodule : gate_trainer_golden
`default_nettype wire

// File: rtl/gate_trainer_self_test.sv
`default_nettype none
// ============================================================================
// Module   : gate_trainer_self_test
// Brief    : Sweeps all 28 a/b/sel vectors into the gate unit and scores y
// Revision : 1.0
// ============================================================================
module gate_trainer_self_test
    import gate_trainer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic [2:0] sel_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [4:0] first_fail
);

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] C_LAST_IDX    = 5'(NUM_VECTORS - 1);
    localparam logic [2:0] C_LAST_SEL    = 3'(NUM_GATES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_ab;
    logic [2:0] r_sel;
    logic [4:0] r_idx;
    logic [3:0] r_settle;
    logic [4:0] r_err_count;
    logic [4:0] r_first_fail;
    logic       r_pass;
    logic       w_golden;
    logic       w_mismatch;
    logic [4:0] w_err_next;
    logic       w_launch;

    gate_trainer_golden u_golden (
        .a   (r_ab[1]),
        .b   (r_ab[0]),
        .sel (r_sel),
        .y   (w_golden)
    );

    assign w_mismatch = (y_in != w_golden);
    assign w_err_next = r_err_count + {4'd0, w_mismatch};
    assign w_launch   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_next = ST_SETTLE;
            ST_SETTLE:        if (r_settle == 4'd0) w_state_next = ST_CHECK;
            ST_CHECK:         w_state_next = (r_idx == C_LAST_IDX) ? ST_DONE : ST_SETTLE;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
        done = (r_state == ST_DONE);
    end

    // Vector sequencing and result accumulation; a new run from IDLE or DONE
    // clears all results and re-applies vector 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ab         <= 2'd0;
            r_sel        <= 3'd0;
            r_idx        <= 5'd0;
            r_settle     <= 4'd0;
            r_err_count  <= 5'd0;
            r_first_fail <= NO_FAIL;
            r_pass       <= 1'b0;
        end else if (w_launch) begin
            r_ab         <= 2'd0;
            r_sel        <= 3'd0;
            r_idx        <= 5'd0;
            r_settle     <= C_SETTLE_LOAD;
            r_err_count  <= 5'd0;
            r_first_fail <= NO_FAIL;
            r_pass       <= 1'b0;
        end else if (r_state == ST_SETTLE) begin
            if (r_settle != 4'd0) begin
                r_settle <= r_settle - 4'd1;
            end
        end else if (r_state == ST_CHECK) begin
            r_err_count <= w_err_next;
            if (w_mismatch && (r_first_fail == NO_FAIL)) begin
                r_first_fail <= r_idx;
            end
            if (r_idx == C_LAST_IDX) begin
                r_pass <= (w_err_next == 5'd0);
            end else begin
                r_idx    <= r_idx + 5'd1;
                r_settle <= C_SETTLE_LOAD;
                if (r_sel == C_LAST_SEL) begin
                    r_sel <= 3'd0;
                    r_ab  <= r_ab + 2'd1;
                end else begin
                    r_sel <= r_sel + 3'd1;
                end
            end
        end
    end

    assign a_out      = r_ab[1];
    assign b_out      = r_ab[0];
    assign sel_out    = r_sel;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign pass       = r_pass;

endmodule : gate_trainer_self_test
`default_nettype wire
